// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: launch FSM encoding and
// the ASCII control characters used by the CR/LF expansion.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } txState_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte buffer for the UART transmit queue. Pointers wrap modulo
// DEPTH; an explicit occupancy counter tells full from empty.
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 pushData,
    output logic [7:0]                 popData,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;

    // Guard the strobes so a caller mistake can never corrupt the pointers.
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    // Storage write; the payload needs no reset.
    // NOTE: the array is left out of reset on purpose: its contents are only
    // read below the write pointer, and a reset here would turn it into flops.
    // Sequential state always uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointer and occupancy update; a simultaneous push and pop keeps level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign popData = mem[rdPtr];
    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and launch sequencer in front of the UART transmitter. Bytes
// are buffered, then launched one at a time with a single-cycle start pulse
// that respects the transmitter's busy flag. Optionally expands LF to CR LF.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter bit CRLF_EXPAND = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   idle
);

    txState_e   state;
    txState_e   stateNext;
    logic [7:0] txDataReg;
    logic [7:0] txDataNext;
    logic       lfPending;
    logic       lfPendingNext;
    logic       fifoPush;
    logic       fifoPop;
    logic [7:0] headData;
    logic       fifoFull;
    logic       fifoEmpty;

    assign fifoPush = in_valid && in_ready;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifoPush),
        .pop      (fifoPop),
        .pushData (in_data),
        .popData  (headData),
        .level    (level),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // Launch sequencer: pending LF first, then the FIFO head, one byte per frame.
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a value unassigned and no latch can be inferred.
    always_comb begin
        stateNext     = state;
        txDataNext    = txDataReg;
        lfPendingNext = lfPending;
        fifoPop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (lfPending && !tx_busy) begin
                    txDataNext    = ASCII_LF;
                    lfPendingNext = 1'b0;
                    stateNext     = LAUNCH;
                end else if (!fifoEmpty && !tx_busy) begin
                    fifoPop = 1'b1;
                    if (CRLF_EXPAND && (headData == ASCII_LF)) begin
                        txDataNext    = ASCII_CR;
                        lfPendingNext = 1'b1;
                    end else begin
                        txDataNext = headData;
                    end
                    stateNext = LAUNCH;
                end
            end
            LAUNCH: begin
                stateNext = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    stateNext = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // FSM state, launched byte and pending-LF flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            txDataReg <= 8'h00;
            lfPending <= 1'b0;
        end else begin
            state     <= stateNext;
            txDataReg <= txDataNext;
            lfPending <= lfPendingNext;
        end
    end

    assign in_ready = !fifoFull;
    assign tx_start = (state == LAUNCH);
    assign tx_data  = txDataReg;
    assign idle     = fifoEmpty && (state == IDLE) && !lfPending;

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte queue and launch sequencer placed directly upstream of the asynchronous UART transmitter. Console logic pushes bytes with a valid/ready handshake. The block buffers them in a FIFO and issues single-cycle start pulses to the transmitter, one byte at a time, honouring its busy flag. It can optionally expand LF into CR LF for terminal output.

## Interface
- `DEPTH`, default 16: FIFO entries; power of 2, minimum 2.
- `CRLF_EXPAND`, default 0: when 1, each popped 0x0A is sent as 0x0D followed by 0x0A.
- `clk` input, 1 bit: single clock shared with the transmitter.
- `reset_n` input, 1 bit: reset, asynchronous and active-low.
- `in_data` input, 8 bits: byte offered by the producer.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: queue can accept; a transfer occurs on a rising edge with `in_valid & in_ready`.
- `tx_start` output, 1 bit: one-cycle launch pulse to the transmitter.
- `tx_data` output, 8 bits: byte being launched; held stable until the next launch.
- `tx_busy` input, 1 bit: transmitter busy flag.
- `level` output, log2(DEPTH)+1 bits: number of bytes stored (0..DEPTH).
- `idle` output, 1 bit: FIFO empty, FSM in IDLE and no CR/LF pending.

## Operation
- FIFO
  - Circular buffer with read and write pointers of log2(DEPTH) bits; both wrap modulo DEPTH.
  - `level` counts stored bytes; it is unchanged on a simultaneous push and pop.
  - `in_ready = (level != DEPTH)`, combinational from registers only.
  - A push when full is impossible by handshake, so there is no overflow state.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE
  - If `lf_pending` is set and `tx_busy` is 0: load `tx_data`=0x0A, clear `lf_pending`, go to LAUNCH.
  - Else if the FIFO is non-empty and `tx_busy` is 0: pop the head.
    - If `CRLF_EXPAND` is 1 and head == 0x0A: load `tx_data`=0x0D and set `lf_pending`.
    - Otherwise load `tx_data`=head.
    - Go to LAUNCH.
- LAUNCH: `tx_start`=1 for this cycle only; go to WAIT_BUSY.
- WAIT_BUSY: stay until `tx_busy`=1, then go to WAIT_DONE. The transmitter raises busy on the edge that samples the start pulse, so WAIT_BUSY normally lasts 1 cycle.
- WAIT_DONE: stay until `tx_busy`=0, then go to IDLE.
- `lf_pending` has priority over a new pop, so CR LF is never split by another byte.
- `tx_start` is a registered output, decoded as `state==LAUNCH`.
- Reset (asynchronous, any state, including mid-byte):
  - Pointers, `level` and `lf_pending` are cleared; `tx_data`=0x00; FSM goes to IDLE.
  - Queued bytes are discarded.
  - A byte already inside the transmitter is not affected; IDLE waits for `tx_busy`=0 before launching.
- Output values in reset: `in_ready`=1, `tx_start`=0, `tx_data`=0x00, `level`=0, `idle`=1.

## Timing
- Latency: a byte pushed at edge E0 into an empty queue with an idle transmitter gives `tx_start` high from E1 to E2; the transmitter samples it at E2.
- Per-byte overhead beyond the transmitter frame: 3 cycles (IDLE→LAUNCH→WAIT_BUSY, plus the return to IDLE).
- Simultaneous push and pop in the same edge are both performed; a push into a full FIFO that pops on the same edge is still refused, because `in_ready` was 0.
- `in_ready` rises the cycle after a pop from full.
- Stuck `tx_busy`=0 in WAIT_BUSY holds the FSM there; no timeout.

## Structure
- Package `uart_pkg`:
  - FSM state encoding (2 bits).
  - Constants `ASCII_CR`=8'h0D and `ASCII_LF`=8'h0A.
- Sub-module `uart_byte_fifo` (parameter DEPTH, width 8):
  - Ports: push, pop, data in/out, `level`, full, empty.
  - Async active-low reset on pointers only; storage is not reset.
- Top level: the FSM, the CRLF logic and the `tx_data` register.

## Test plan
- Single byte: push 0x41 into an idle queue → `tx_start` pulses exactly once, 1 cycle wide, with `tx_data`=0x41 two edges after the push; `level` goes 1→0.
- Fill: with `tx_busy` held 1, push 16 bytes 0x00..0x0F → `in_ready`=0 at `level`=16; a 17th offer is not accepted. Release busy → bytes are launched in order 0x00..0x0F, with wrap-around verified by a second fill.
- Busy handshake: model the transmitter with busy asserted 1 cycle after start for 20 cycles → no second `tx_start` until busy falls; exactly one pulse per byte.
- CRLF expansion: with `CRLF_EXPAND`=1, push 0x48, 0x0A, 0x49 → launches 0x48, 0x0D, 0x0A, 0x49. With `CRLF_EXPAND`=0 → launches 0x48, 0x0A, 0x49.
- Simultaneous push and pop: at `level`=3, push on the pop edge → `level` stays 3 and data order is preserved.
- Reset mid-operation: assert `reset_n`=0 in WAIT_DONE with `level`=5 → immediately `level`=0, `tx_start`=0, `in_ready`=1. After release, no launch occurs while `tx_busy`=1.
